// File: rtl/sm83_dbg_ifc_p_if.sv
// SM83 debug port bundle: CPU observation/override signals plus the toggle-handshake command/reply channel.
// master = debug host and CPU side, slave = the debug controller.
interface sm83_dbg_ifc_p_if #(
    parameter int NUM_BP = 4
);
    logic              ncyc;
    logic [7:0]        probe;
    logic [15:0]       pc;
    logic [15:0]       sp;
    logic [7:4]        f;
    logic              ime;
    logic [7:0]        data;
    logic              drv;
    logic              halt;
    logic              no_inc;
    logic [7:0]        data_rx;
    logic              data_rx_valid;
    logic              data_rx_seq;
    logic              data_rx_ack;
    logic [7:0]        data_tx;
    logic              data_tx_seq;
    logic              data_tx_ack;
    logic              ena;
    logic [NUM_BP-1:0] bp_hit;

    modport master (
        output ncyc, probe, pc, sp, f, ime, data_rx, data_rx_valid, data_rx_seq, data_tx_ack,
        input  data, drv, halt, no_inc, data_rx_ack, data_tx, data_tx_seq, ena, bp_hit
    );

    modport slave (
        input  ncyc, probe, pc, sp, f, ime, data_rx, data_rx_valid, data_rx_seq, data_tx_ack,
        output data, drv, halt, no_inc, data_rx_ack, data_tx, data_tx_seq, ena, bp_hit
    );
endinterface

// File: rtl/sm83_dbg_ifc_p.sv
// SM83 debug controller: command decode, halt/step with bus injection, PC breakpoints, one reply per command.
// Commands decode on an ncyc boundary in IDLE; a command is acked only once its reply is acked (rejects ack at once).
module sm83_dbg_ifc_p #(
    parameter int NUM_BP         = 4,
    parameter int TIMEOUT        = 60,
    parameter bit INITIAL_ENABLE = 1'b0
) (
    input  logic                 clk,
    input  logic                 nreset,
    sm83_dbg_ifc_p_if.slave      bus
);
    localparam int CW = ($clog2(TIMEOUT + 1) < 5) ? 5 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HALT, STEP, SEND} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [15:0]       sr;
    logic [3:0]        ret;
    logic              halt_r;
    logic              step_rel;
    logic              tx_pend;
    logic [15:0]       bp [NUM_BP];
    logic [NUM_BP-1:0] en;
    logic [NUM_BP-1:0] bp_match;
    logic [3:0]        slot_vld;
    logic [7:0]        slot_dat [4];
    logic [7:0]        en8;
    logic [3:0]        hit_idx;
    logic [3:0]        nib;
    logic [3:0]        op_hi;
    logic [3:0]        op_lo;
    logic              cmd_go;
    logic              op_def;
    logic              halt_only;
    logic              free_op;
    logic              op_ok;

    // Breakpoints are blind during the one cycle halt is released for a step,
    // otherwise a step from a breakpoint address would immediately re-halt.
    always_comb begin
        bp_match = '0;
        for (int k = 0; k < NUM_BP; k++)
            bp_match[k] = en[k] && (bp[k] == bus.pc) && !step_rel;
    end

    assign bus.halt = halt_r | (|bp_match);

    always_comb begin
        hit_idx = 4'hF;
        for (int k = NUM_BP - 1; k >= 0; k--)
            if (bus.bp_hit[k]) hit_idx = 4'(k);
        en8 = '0;
        en8[NUM_BP-1:0] = en;
        cnt_nx = cnt + CW'(1);
    end

    always_comb begin
        nib = 4'h0;
        case (ret)
            4'd0:    nib = {bus.ime, bus.ena, bus.no_inc, bus.halt};
            4'd1:    nib = bus.f;
            4'd2:    nib = bus.probe[3:0];
            4'd3:    nib = bus.probe[7:4];
            4'd4:    nib = bus.pc[3:0];
            4'd5:    nib = bus.pc[7:4];
            4'd6:    nib = bus.pc[11:8];
            4'd7:    nib = bus.pc[15:12];
            4'd8:    nib = bus.sp[3:0];
            4'd9:    nib = bus.sp[7:4];
            4'd10:   nib = bus.sp[11:8];
            4'd11:   nib = bus.sp[15:12];
            4'd12:   nib = hit_idx;
            4'd13:   nib = 4'(NUM_BP - 1);
            4'd14:   nib = en8[3:0];
            default: nib = en8[7:4];
        endcase
    end

    assign op_hi  = bus.data_rx[7:4];
    assign op_lo  = bus.data_rx[3:0];
    assign cmd_go = (state == IDLE) && bus.ncyc && (bus.data_rx_seq != bus.data_rx_ack);

    always_comb begin
        op_def    = 1'b0;
        halt_only = 1'b0;
        free_op   = 1'b0;
        case (op_hi)
            4'h0: begin
                op_def    = (op_lo <= 4'd3);
                halt_only = (op_lo == 4'd2);
                free_op   = (op_lo == 4'd1);
            end
            4'h1: begin
                op_def  = 1'b1;
                free_op = 1'b1;
            end
            4'h2: begin
                op_def    = (op_lo <= 4'd2);
                halt_only = (op_lo == 4'd0);
                free_op   = (op_lo == 4'd2);
            end
            4'h4, 4'h5: begin
                op_def    = (int'(op_lo) < NUM_BP);
                halt_only = 1'b1;
            end
            4'h8, 4'h9: op_def = (op_lo < 4'd4);
            default: ;
        endcase
        op_ok = bus.data_rx_valid && op_def && (bus.ena || free_op) && (bus.halt || !halt_only);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state           <= IDLE;
            cnt             <= '0;
            sr              <= '0;
            ret             <= '0;
            halt_r          <= 1'b0;
            step_rel        <= 1'b0;
            tx_pend         <= 1'b0;
            en              <= '0;
            slot_vld        <= '0;
            bus.no_inc      <= 1'b0;
            bus.drv         <= 1'b0;
            bus.data        <= '0;
            bus.ena         <= INITIAL_ENABLE;
            bus.bp_hit      <= '0;
            bus.data_tx     <= '0;
            bus.data_rx_ack <= bus.data_rx_seq;
            bus.data_tx_seq <= bus.data_tx_ack;
            for (int k = 0; k < NUM_BP; k++) bp[k] <= '0;
            for (int j = 0; j < 4; j++) slot_dat[j] <= '0;
        end else begin
            step_rel <= 1'b0;
            if (|bp_match) begin
                halt_r     <= 1'b1;
                bus.bp_hit <= bus.bp_hit | bp_match;
            end
            case (state)
                IDLE: if (cmd_go) begin
                    if (!op_ok) begin
                        bus.data_rx_ack <= bus.data_rx_seq;
                    end else begin
                        state   <= SEND;
                        tx_pend <= 1'b1;
                        case (op_hi)
                            4'h0: case (op_lo[1:0])
                                2'd0: begin
                                    halt_r  <= 1'b1;
                                    state   <= HALT;
                                    tx_pend <= 1'b0;
                                    cnt     <= '0;
                                end
                                2'd2: begin
                                    halt_r   <= 1'b0;
                                    step_rel <= 1'b1;
                                    state    <= STEP;
                                    tx_pend  <= 1'b0;
                                    cnt      <= CW'(2);
                                    bus.drv  <= slot_vld[0];
                                    bus.data <= slot_dat[0];
                                end
                                2'd3: begin
                                    halt_r     <= 1'b0;
                                    bus.no_inc <= 1'b0;
                                    bus.bp_hit <= '0;
                                end
                                default: ;
                            endcase
                            4'h1: sr <= {op_lo, sr[15:4]};
                            4'h2: case (op_lo[1:0])
                                2'd0:    bus.no_inc <= sr[0];
                                2'd1:    if (!bus.halt && sr[7:0] == 8'h8A) bus.ena <= 1'b0;
                                default: if (sr[7:0] == 8'h8A) bus.ena <= 1'b1;
                            endcase
                            4'h4: for (int k = 0; k < NUM_BP; k++)
                                if (int'(op_lo) == k) begin
                                    bp[k] <= sr;
                                    en[k] <= 1'b1;
                                end
                            4'h5: for (int k = 0; k < NUM_BP; k++)
                                if (int'(op_lo) == k) en[k] <= 1'b0;
                            4'h8: begin
                                slot_vld[op_lo[1:0]] <= 1'b1;
                                slot_dat[op_lo[1:0]] <= sr[7:0];
                            end
                            4'h9: slot_vld[op_lo[1:0]] <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                HALT: begin
                    if (cnt == CW'(TIMEOUT)) begin
                        state   <= SEND;
                        tx_pend <= 1'b1;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                STEP: begin
                    halt_r <= 1'b1;
                    if (cnt == CW'(TIMEOUT)) begin
                        state    <= SEND;
                        tx_pend  <= 1'b1;
                        bus.drv  <= 1'b0;
                        bus.data <= '0;
                    end else begin
                        cnt <= cnt_nx;
                        // drv/data are registered against the counter value they will accompany
                        if (cnt_nx < CW'(16)) begin
                            bus.drv  <= slot_vld[cnt_nx[3:2]];
                            bus.data <= slot_dat[cnt_nx[3:2]];
                        end else begin
                            bus.drv  <= 1'b0;
                            bus.data <= '0;
                        end
                    end
                end
                default: begin
                    // Reply is captured one cycle after entry so it reflects the command's own effect.
                    if (tx_pend) begin
                        bus.data_tx     <= {ret, nib};
                        bus.data_tx_seq <= ~bus.data_tx_seq;
                        tx_pend         <= 1'b0;
                    end else if (bus.data_tx_seq == bus.data_tx_ack) begin
                        bus.data_rx_ack <= bus.data_rx_seq;
                        ret             <= ret + 4'd1;
                        state           <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm83_dbg_ifc_p.sv
// Directed bench for sm83_dbg_ifc_p: enable, halt, breakpoint, step injection, rejects, handshake, reset abort.
module tb_sm83_dbg_ifc_p;
    logic clk = 1'b0;
    logic nreset = 1'b1;
    int   total = 0;
    int   bad = 0;

    sm83_dbg_ifc_p_if #(.NUM_BP(4)) bus ();

    sm83_dbg_ifc_p #(.NUM_BP(4), .TIMEOUT(60), .INITIAL_ENABLE(1'b0)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op);
        bus.data_rx       = op;
        bus.data_rx_valid = 1'b1;
        bus.data_rx_seq   = ~bus.data_rx_seq;
    endtask

    // Waits for a reply, checks it, acks it and waits for the command ack.
    task automatic wait_reply(input string tag, input logic [7:0] exp);
        bit got = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step_clk();
            if (bus.data_tx_seq != bus.data_tx_ack) got = 1'b1;
        end
        check({tag, "_seen"}, 16'(got), 16'd1);
        if (got) begin
            check(tag, 16'(bus.data_tx), 16'(exp));
            bus.data_tx_ack = ~bus.data_tx_ack;
            for (int i = 0; i < 5 && !done; i++) begin
                step_clk();
                if (bus.data_rx_ack == bus.data_rx_seq) done = 1'b1;
            end
            check({tag, "_ack"}, 16'(done), 16'd1);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] exp);
        issue(op);
        wait_reply(tag, exp);
    endtask

    task automatic do_reject(input string tag, input logic [7:0] op);
        logic tx_before;
        tx_before = bus.data_tx_seq;
        issue(op);
        step_clk();
        check({tag, "_ack"}, 16'(bus.data_rx_ack), 16'(bus.data_rx_seq));
        step_clk();
        check({tag, "_txseq"}, 16'(bus.data_tx_seq), 16'(tx_before));
    endtask

    initial begin
        int held_bad;
        bus.ncyc          = 1'b1;
        bus.probe         = 8'h5A;
        bus.pc            = 16'h1234;
        bus.sp            = 16'hFFFE;
        bus.f             = 4'hB;
        bus.ime           = 1'b1;
        bus.data_rx       = 8'h00;
        bus.data_rx_valid = 1'b0;
        bus.data_rx_seq   = 1'b1;
        bus.data_tx_ack   = 1'b0;
        #3 nreset = 1'b0;
        #1;
        check("rst_halt",   16'(bus.halt),        16'd0);
        check("rst_drv",    16'(bus.drv),         16'd0);
        check("rst_ena",    16'(bus.ena),         16'd0);
        check("rst_noinc",  16'(bus.no_inc),      16'd0);
        check("rst_bphit",  16'(bus.bp_hit),      16'd0);
        check("rst_datatx", 16'(bus.data_tx),     16'd0);
        check("rst_rxack",  16'(bus.data_rx_ack), 16'd1);
        check("rst_txseq",  16'(bus.data_tx_seq), 16'd0);
        step_clk();
        step_clk();
        nreset = 1'b1;
        step_clk();

        do_reject("rej_halt_dis", 8'h00);
        check("rej_halt_level", 16'(bus.halt), 16'd0);

        // sr ends as 0x008A so ENABLE takes effect
        do_cmd("ld_a",   8'h1A, 8'h08);
        do_cmd("ld_8",   8'h18, 8'h1B);
        do_cmd("ld_0a",  8'h10, 8'h2A);
        do_cmd("ld_0b",  8'h10, 8'h35);
        do_cmd("enable", 8'h22, 8'h44);
        check("ena_set", 16'(bus.ena), 16'd1);

        do_cmd("halt", 8'h00, 8'h53);
        check("halt_level", 16'(bus.halt), 16'd1);

        do_reject("rej_bpset4", 8'h44);

        do_cmd("ld_1", 8'h11, 8'h62);
        do_cmd("ld_0", 8'h10, 8'h71);
        do_cmd("ld_2", 8'h12, 8'h8E);
        do_cmd("ld_0c", 8'h10, 8'h9F);
        do_cmd("bpset1", 8'h41, 8'hAF);
        do_cmd("cont", 8'h03, 8'hBF);
        check("cont_halt", 16'(bus.halt), 16'd0);

        bus.pc = 16'h0201;
        #1;
        check("bp_halt_same", 16'(bus.halt), 16'd1);
        step_clk();
        check("bp_hit", 16'(bus.bp_hit), 16'b0010);
        bus.pc = 16'h1234;
        step_clk();
        check("bp_halt_held", 16'(bus.halt), 16'd1);

        do_cmd("nib12", 8'h01, 8'hC1);
        do_cmd("nib13", 8'h01, 8'hD3);
        do_cmd("nib14", 8'h01, 8'hE2);
        do_cmd("ld_e",  8'h1E, 8'hF0);
        do_cmd("ld_3",  8'h13, 8'h0D);
        do_cmd("ld_0d", 8'h10, 8'h1B);
        do_cmd("ld_0e", 8'h10, 8'h2A);
        do_cmd("inj0",  8'h80, 8'h35);

        issue(8'h02);
        step_clk();
        check("stp2_drv",  16'(bus.drv),  16'd1);
        check("stp2_data", 16'(bus.data), 16'h3E);
        check("stp2_halt", 16'(bus.halt), 16'd0);
        step_clk();
        check("stp3_drv",  16'(bus.drv),  16'd1);
        check("stp3_data", 16'(bus.data), 16'h3E);
        check("stp3_halt", 16'(bus.halt), 16'd1);
        step_clk();
        check("stp4_drv", 16'(bus.drv), 16'd0);
        for (int i = 0; i < 12; i++) step_clk();
        check("stp16_drv", 16'(bus.drv), 16'd0);
        check("stp16_noreply", 16'(bus.data_tx_seq), 16'(bus.data_tx_ack));
        wait_reply("step", 8'h44);
        step_clk();
        check("step_one_reply", 16'(bus.data_tx_seq), 16'(bus.data_tx_ack));

        issue(8'h01);
        held_bad = 0;
        for (int i = 0; i < 20 && bus.data_tx_seq == bus.data_tx_ack; i++) step_clk();
        check("hs_reply", 16'(bus.data_tx), 16'h53);
        for (int i = 0; i < 10; i++) begin
            step_clk();
            if (bus.data_rx_ack == bus.data_rx_seq) held_bad++;
        end
        check("hs_held", 16'(held_bad), 16'd0);
        wait_reply("hs_done", 8'h53);

        do_cmd("inj1", 8'h81, 8'h62);

        issue(8'h02);
        step_clk();
        step_clk();
        step_clk();
        step_clk();
        check("stp5_drv",  16'(bus.drv),  16'd1);
        check("stp5_halt", 16'(bus.halt), 16'd1);
        nreset = 1'b0;
        #1;
        check("rst5_drv",   16'(bus.drv),         16'd0);
        check("rst5_halt",  16'(bus.halt),        16'd0);
        check("rst5_rxack", 16'(bus.data_rx_ack), 16'(bus.data_rx_seq));
        step_clk();
        nreset = 1'b1;
        for (int i = 0; i < 80; i++) step_clk();
        check("rst5_noreply", 16'(bus.data_tx_seq), 16'(bus.data_tx_ack));
        check("rst5_datatx",  16'(bus.data_tx),     16'd0);
        do_cmd("post_rst", 8'h01, 8'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
